memory_cycle: RTL and testbench

Memory stage of the five-stage pipelined RISC-V core. It consumes the EX/MEM pipeline outputs, performs word loads and stores against an internal data memory, and registers the results into the MEM/WB pipeline register for the writeback stage. A programmable wait-state FSM models slow memory. While an access is in progress, the block asserts a stall to the hazard unit and injects a bubble into writeback.

---
 rtl/memory_cycle_if.sv | 28 ++
 rtl/memory_cycle.sv | 86 ++++++++
 tb/tb_memory_cycle.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_cycle_if.sv
// EX/MEM -> MEM/WB bundle for the memory stage: M-side inputs, W-side registered outputs, stall.
interface memory_cycle_if;
    logic        RegWriteM;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M;
    logic [31:0] WriteDataM;
    logic [31:0] ALU_ResultM;

    logic        StallM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W;
    logic [31:0] ALU_ResultW;
    logic [31:0] ReadDataW;

    modport master (
        output RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM,
        input  StallM, RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW
    );

    modport slave (
        input  RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM,
        output StallM, RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW
    );
endinterface

// File: rtl/memory_cycle.sv
// Memory stage: word data memory with programmable wait states and the MEM/WB pipeline register.
module memory_cycle #(
    parameter int DEPTH_LOG2 = 10,
    parameter int MEM_WAIT   = 0
) (
    input logic           clk,
    input logic           rst,
    memory_cycle_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam bit         HAS_WAIT  = (MEM_WAIT > 0);
    localparam logic [3:0] WAIT_INIT = HAS_WAIT ? 4'(MEM_WAIT - 1) : 4'd0;

    state_t                state;
    logic [3:0]            cnt;
    logic [31:0]           mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  access;
    logic                  stall;
    logic                  wrEn;

    // Address bits outside the word index are dropped, so addresses wrap.
    assign idx    = bus.ALU_ResultM[DEPTH_LOG2+1:2];
    assign access = bus.MemWriteM | (bus.ResultSrcM == 2'b01);

    // Gated by rst so a reset mid-access drops the stall and any pending store at once.
    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    stall = access && HAS_WAIT;
                BUSY:    stall = (cnt != 4'd0);
                default: stall = 1'b0;
            endcase
        end
        wrEn = !rst && bus.MemWriteM && !stall;
    end

    assign bus.StallM = stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.RegWriteW  <= 1'b0;
            bus.ResultSrcW <= '0;
            bus.RD_W       <= '0;
            bus.PCPlus4W   <= '0;
            bus.ALU_ResultW <= '0;
            bus.ReadDataW  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && HAS_WAIT) begin
                        state <= BUSY;
                        cnt   <= WAIT_INIT;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                    else             state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (stall) begin
                bus.RegWriteW  <= 1'b0;
                bus.ResultSrcW <= '0;
                bus.RD_W       <= '0;
            end else begin
                bus.RegWriteW   <= bus.RegWriteM;
                bus.ResultSrcW  <= bus.ResultSrcM;
                bus.RD_W        <= bus.RD_M;
                bus.PCPlus4W    <= bus.PCPlus4M;
                bus.ALU_ResultW <= bus.ALU_ResultM;
                bus.ReadDataW   <= mem[idx];
            end
        end
    end

    // Not reset: memory contents survive rst.
    always_ff @(posedge clk) begin
        if (wrEn) mem[idx] <= bus.WriteDataM;
    end
endmodule

// File: tb/tb_memory_cycle.sv
// Scoreboard bench for memory_cycle: five instances covering wait-state, wrap and reset configurations.
module tb_memory_cycle;
    typedef struct packed {
        logic        regWrite;
        logic        memWrite;
        logic [1:0]  resultSrc;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] wdata;
        logic [31:0] alu;
    } mrec_t;

    typedef struct packed {
        logic        regWrite;
        logic [1:0]  resultSrc;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] rdata;
    } wrec_t;

    typedef struct {
        wrec_t v;
        wrec_t mask;
    } sbe_t;

    localparam wrec_t FULL = '1;
    localparam wrec_t NORD = {{72{1'b1}}, 32'h0};

    logic  clk = 1'b0;
    logic  rstA;
    logic  rst4;
    mrec_t m   [5];
    wrec_t w   [5];
    logic  stl [5];
    sbe_t  last[5];
    sbe_t  sb[$];
    int    total = 0;
    int    bad = 0;

    always #5 clk = ~clk;

    // 0: wait 0, 1: wait 3, 2: wait 2, 3: depth 16 wait 0, 4: wait 4 with its own reset
    for (genvar g = 0; g < 5; g++) begin : g_dut
        memory_cycle_if ifc();
        assign {ifc.RegWriteM, ifc.MemWriteM, ifc.ResultSrcM, ifc.RD_M,
                ifc.PCPlus4M, ifc.WriteDataM, ifc.ALU_ResultM} = m[g];
        assign w[g]   = {ifc.RegWriteW, ifc.ResultSrcW, ifc.RD_W,
                         ifc.PCPlus4W, ifc.ALU_ResultW, ifc.ReadDataW};
        assign stl[g] = ifc.StallM;
        memory_cycle #(
            .DEPTH_LOG2(g == 3 ? 4 : 10),
            .MEM_WAIT  (g == 1 ? 3 : g == 2 ? 2 : g == 4 ? 4 : 0)
        ) dut (
            .clk(clk),
            .rst(g == 4 ? rst4 : rstA),
            .bus(ifc)
        );
    end

    function automatic mrec_t mk(input logic rw, input logic mw, input logic [1:0] src,
                                 input logic [4:0] dst, input logic [31:0] pc4,
                                 input logic [31:0] wd, input logic [31:0] alu);
        mk = '{regWrite: rw, memWrite: mw, resultSrc: src, rd: dst, pc4: pc4, wdata: wd, alu: alu};
    endfunction

    function automatic wrec_t expOf(input mrec_t r, input logic [31:0] rdv);
        expOf = {r.regWrite, r.resultSrc, r.rd, r.pc4, r.alu, rdv};
    endfunction

    function automatic bit isAccess(input mrec_t r);
        isAccess = r.memWrite || (r.resultSrc == 2'b01);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int k, input mrec_t r, input logic [31:0] rdv, input bit chk);
        sbe_t e;
        m[k]   = r;
        e.v    = expOf(r, rdv);
        e.mask = chk ? FULL : NORD;
        sb.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        sbe_t e;
        rstA = 1'b1;
        rst4 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            m[k] = mk(1'b1, 1'b1, 2'b11, 5'h1f, 32'hFFFF_FFFC, 32'h1234_5678, 32'h40);
            last[k].v = '0;
            last[k].mask = FULL;
        end
        repeat (2) tick();
        for (int k = 0; k < 5; k++) begin
            total++;
            if (w[k] !== '0) begin
                bad++;
                $display("FAIL reset_w dut%0d: got %h want 0", k, w[k]);
            end
            total++;
            if (stl[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_stall dut%0d: got %b want 0", k, stl[k]);
            end
        end
        for (int k = 0; k < 5; k++) m[k] = '0;
        rstA = 1'b0;
        rst4 = 1'b0;
        issue(0, mk(1'b1, 1'b0, 2'b00, 5'd5, 32'h104, 32'h0, 32'h1234), 32'h0, 1'b0);
        total++;
        if (stl[0] !== 1'b0) begin
            bad++;
            $display("FAIL rtype_stall: got %b want 0", stl[0]);
        end
        tick();
        e = sb.pop_front();
        total++;
        if ((w[0] & e.mask) !== (e.v & e.mask)) begin
            bad++;
            $display("FAIL rtype_w: got %h want %h", w[0] & e.mask, e.v & e.mask);
        end
        last[0] = e;
        m[0] = '0;
    endtask

    task automatic test_single_cycle();
        mrec_t       ops[4];
        logic [31:0] rdv[4];
        bit          chk[4];
        sbe_t        e;
        ops[0] = mk(1'b0, 1'b1, 2'b00, 5'd0, 32'h200, 32'hDEAD_BEEF, 32'h40); rdv[0] = 32'h0;         chk[0] = 1'b0;
        ops[1] = mk(1'b1, 1'b0, 2'b01, 5'd7, 32'h204, 32'h0,         32'h40); rdv[1] = 32'hDEAD_BEEF; chk[1] = 1'b1;
        ops[2] = mk(1'b1, 1'b1, 2'b01, 5'd8, 32'h208, 32'hCAFE_F00D, 32'h40); rdv[2] = 32'hDEAD_BEEF; chk[2] = 1'b1;
        ops[3] = mk(1'b1, 1'b0, 2'b01, 5'd9, 32'h20C, 32'h0,         32'h43); rdv[3] = 32'hCAFE_F00D; chk[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(0, ops[i], rdv[i], chk[i]);
            total++;
            if (stl[0] !== 1'b0) begin
                bad++;
                $display("FAIL w0_stall op%0d: got %b want 0", i, stl[0]);
            end
            tick();
            e = sb.pop_front();
            total++;
            if ((w[0] & e.mask) !== (e.v & e.mask)) begin
                bad++;
                $display("FAIL w0_result op%0d: got %h want %h", i, w[0] & e.mask, e.v & e.mask);
            end
            last[0] = e;
        end
        m[0] = '0;
    endtask

    task automatic test_wait3();
        mrec_t       ops[3];
        logic [31:0] rdv[3];
        bit          chk[3];
        int          n;
        sbe_t        e;
        wrec_t       b;
        ops[0] = mk(1'b0, 1'b1, 2'b00, 5'd0, 32'h300, 32'h0BAD_F00D, 32'h40); rdv[0] = 32'h0;         chk[0] = 1'b0;
        ops[1] = mk(1'b1, 1'b0, 2'b01, 5'd9, 32'h304, 32'h0,         32'h40); rdv[1] = 32'h0BAD_F00D; chk[1] = 1'b1;
        ops[2] = mk(1'b1, 1'b0, 2'b00, 5'd3, 32'h308, 32'h0,         32'h8);  rdv[2] = 32'h0;         chk[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n = isAccess(ops[i]) ? 3 : 0;
            issue(1, ops[i], rdv[i], chk[i]);
            for (int s = 0; s < n; s++) begin
                total++;
                if (stl[1] !== 1'b1) begin
                    bad++;
                    $display("FAIL w3_stall op%0d cyc%0d: got %b want 1", i, s, stl[1]);
                end
                tick();
                b = last[1].v; b.regWrite = 1'b0; b.resultSrc = '0; b.rd = '0;
                total++;
                if ((w[1] & last[1].mask) !== (b & last[1].mask)) begin
                    bad++;
                    $display("FAIL w3_bubble op%0d cyc%0d: got %h want %h", i, s, w[1] & last[1].mask, b & last[1].mask);
                end
            end
            total++;
            if (stl[1] !== 1'b0) begin
                bad++;
                $display("FAIL w3_done_stall op%0d: got %b want 0", i, stl[1]);
            end
            tick();
            e = sb.pop_front();
            total++;
            if ((w[1] & e.mask) !== (e.v & e.mask)) begin
                bad++;
                $display("FAIL w3_result op%0d: got %h want %h", i, w[1] & e.mask, e.v & e.mask);
            end
            last[1] = e;
        end
        m[1] = '0;
    endtask

    task automatic test_wait2_store();
        mrec_t       ops[3];
        logic [31:0] rdv[3];
        bit          chk[3];
        bit          memKnown[3];
        logic [31:0] memBefore[3];
        logic [31:0] memAfter[3];
        sbe_t        e;
        wrec_t       b;
        ops[0] = mk(1'b0, 1'b1, 2'b00, 5'd0, 32'h400, 32'h22, 32'h8); rdv[0] = 32'h0;  chk[0] = 1'b0;
        ops[1] = mk(1'b0, 1'b1, 2'b00, 5'd0, 32'h404, 32'h11, 32'h8); rdv[1] = 32'h22; chk[1] = 1'b1;
        ops[2] = mk(1'b1, 1'b0, 2'b01, 5'd4, 32'h408, 32'h0,  32'h8); rdv[2] = 32'h11; chk[2] = 1'b1;
        memKnown[0] = 1'b0; memBefore[0] = 32'h0;  memAfter[0] = 32'h22;
        memKnown[1] = 1'b1; memBefore[1] = 32'h22; memAfter[1] = 32'h11;
        memKnown[2] = 1'b1; memBefore[2] = 32'h11; memAfter[2] = 32'h11;
        for (int i = 0; i < 3; i++) begin
            issue(2, ops[i], rdv[i], chk[i]);
            for (int s = 0; s < 2; s++) begin
                total++;
                if (stl[2] !== 1'b1) begin
                    bad++;
                    $display("FAIL w2_stall op%0d cyc%0d: got %b want 1", i, s, stl[2]);
                end
                tick();
                b = last[2].v; b.regWrite = 1'b0; b.resultSrc = '0; b.rd = '0;
                total++;
                if ((w[2] & last[2].mask) !== (b & last[2].mask)) begin
                    bad++;
                    $display("FAIL w2_bubble op%0d cyc%0d: got %h want %h", i, s, w[2] & last[2].mask, b & last[2].mask);
                end
                if (memKnown[i]) begin
                    total++;
                    if (g_dut[2].dut.mem[2] !== memBefore[i]) begin
                        bad++;
                        $display("FAIL w2_mem_early op%0d cyc%0d: got %h want %h", i, s, g_dut[2].dut.mem[2], memBefore[i]);
                    end
                end
            end
            tick();
            e = sb.pop_front();
            total++;
            if ((w[2] & e.mask) !== (e.v & e.mask)) begin
                bad++;
                $display("FAIL w2_result op%0d: got %h want %h", i, w[2] & e.mask, e.v & e.mask);
            end
            last[2] = e;
            total++;
            if (g_dut[2].dut.mem[2] !== memAfter[i]) begin
                bad++;
                $display("FAIL w2_mem_done op%0d: got %h want %h", i, g_dut[2].dut.mem[2], memAfter[i]);
            end
        end
        m[2] = '0;
    endtask

    task automatic test_wrap();
        mrec_t       ops[6];
        logic [31:0] rdv[6];
        bit          chk[6];
        sbe_t        e;
        ops[0] = mk(1'b0, 1'b1, 2'b00, 5'd0, 32'h500, 32'hAA,   32'h44); rdv[0] = 32'h0;    chk[0] = 1'b0;
        ops[1] = mk(1'b1, 1'b0, 2'b01, 5'd1, 32'h504, 32'h0,    32'h04); rdv[1] = 32'hAA;   chk[1] = 1'b1;
        ops[2] = mk(1'b1, 1'b0, 2'b01, 5'd2, 32'h508, 32'h0,    32'h84); rdv[2] = 32'hAA;   chk[2] = 1'b1;
        ops[3] = mk(1'b0, 1'b1, 2'b00, 5'd0, 32'h50C, 32'h5A5A, 32'h00); rdv[3] = 32'h0;    chk[3] = 1'b0;
        ops[4] = mk(1'b1, 1'b0, 2'b01, 5'd3, 32'h510, 32'h0,    32'h03); rdv[4] = 32'h5A5A; chk[4] = 1'b1;
        ops[5] = mk(1'b1, 1'b0, 2'b01, 5'd4, 32'h514, 32'h0,    32'h00); rdv[5] = 32'h5A5A; chk[5] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            issue(3, ops[i], rdv[i], chk[i]);
            tick();
            e = sb.pop_front();
            total++;
            if ((w[3] & e.mask) !== (e.v & e.mask)) begin
                bad++;
                $display("FAIL wrap_result op%0d: got %h want %h", i, w[3] & e.mask, e.v & e.mask);
            end
            last[3] = e;
        end
        m[3] = '0;
    endtask

    task automatic test_reset_mid();
        mrec_t       ops[2];
        logic [31:0] rdv[2];
        bit          chk[2];
        sbe_t        e;
        wrec_t       b;
        ops[0] = mk(1'b0, 1'b1, 2'b00, 5'd0,  32'h600, 32'h77, 32'h10); rdv[0] = 32'h0;  chk[0] = 1'b0;
        ops[1] = mk(1'b1, 1'b0, 2'b01, 5'd12, 32'h604, 32'h0,  32'h10); rdv[1] = 32'h77; chk[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin
                // abort a store of 0x55 in its second stall cycle; the load then shows 0x77 survived
                issue(4, mk(1'b0, 1'b1, 2'b00, 5'd0, 32'h700, 32'h55, 32'h10), 32'h77, 1'b0);
                tick();
                total++;
                if (stl[4] !== 1'b1) begin
                    bad++;
                    $display("FAIL rmid_stall_pre: got %b want 1", stl[4]);
                end
                rst4 = 1'b1;
                #1;
                total++;
                if (stl[4] !== 1'b0) begin
                    bad++;
                    $display("FAIL rmid_stall_drop: got %b want 0", stl[4]);
                end
                total++;
                if (w[4] !== '0) begin
                    bad++;
                    $display("FAIL rmid_w_clear: got %h want 0", w[4]);
                end
                tick();
                total++;
                if (g_dut[4].dut.mem[4] !== 32'h77) begin
                    bad++;
                    $display("FAIL rmid_mem: got %h want 00000077", g_dut[4].dut.mem[4]);
                end
                void'(sb.pop_front());
                last[4].v = '0;
                last[4].mask = FULL;
                m[4] = ops[1];
                rst4 = 1'b0;
            end
            issue(4, ops[i], rdv[i], chk[i]);
            for (int s = 0; s < 4; s++) begin
                total++;
                if (stl[4] !== 1'b1) begin
                    bad++;
                    $display("FAIL w4_stall op%0d cyc%0d: got %b want 1", i, s, stl[4]);
                end
                tick();
                b = last[4].v; b.regWrite = 1'b0; b.resultSrc = '0; b.rd = '0;
                total++;
                if ((w[4] & last[4].mask) !== (b & last[4].mask)) begin
                    bad++;
                    $display("FAIL w4_bubble op%0d cyc%0d: got %h want %h", i, s, w[4] & last[4].mask, b & last[4].mask);
                end
            end
            tick();
            e = sb.pop_front();
            total++;
            if ((w[4] & e.mask) !== (e.v & e.mask)) begin
                bad++;
                $display("FAIL w4_result op%0d: got %h want %h", i, w[4] & e.mask, e.v & e.mask);
            end
            last[4] = e;
        end
        m[4] = '0;
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_wait3();
        test_wait2_store();
        test_wrap();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
